// File: rtl/layer1_accumulator.sv
// layer1_accumulator
//
// Sequential multiply-accumulate stage feeding the layer-1 ReLU. A frame is
// N_INPUTS beats; each beat carries one unsigned 4-bit activation and 32
// signed 4-bit weights. Every beat adds weight[j] * activation into acc[j].
// After the last beat, one FLUSH cycle scales each accumulator (arithmetic
// shift right by SHIFT), narrows it to 8 bits and registers the packed
// result on sumOut with trigger held high until the next start.
//
// Optional feature macro: LAYER1_ACC_SATURATE_EN
//   defined   -> narrowed lanes are clamped to [-128, 127]
//   undefined -> narrowed lanes keep the low 8 bits (two's-complement wrap)
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst_n      in   1    synchronous active-low reset
//   start      in   1    frame start request (honoured in IDLE and DONE)
//   inValid    in   1    inData/weightsIn valid this cycle
//   inReady    out  1    block accepts a beat this cycle
//   inData     in   4    unsigned activation
//   weightsIn  in   128  32 signed 4-bit weights, neuron j at [4j+3:4j]
//   sumOut     out  256  32 signed 8-bit sums, neuron j at [8j+7:8j]
//   trigger    out  1    high while sumOut holds a completed frame
module layer1_accumulator #(
    parameter int unsigned N_INPUTS = 64,
    parameter int unsigned ACC_W    = 16,
    parameter int unsigned SHIFT    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         inValid,
    output logic         inReady,
    input  logic [3:0]   inData,
    input  logic [127:0] weightsIn,
    output logic [255:0] sumOut,
    output logic         trigger
);

    localparam int unsigned CNT_W = $clog2(N_INPUTS + 1);
    localparam int unsigned LANES = 32;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StFlush,
        StDone
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [CNT_W-1:0]        r_count;
    logic signed [ACC_W-1:0] r_acc [LANES];
    logic                    r_in_ready;
    logic                    r_trigger;
    logic [255:0]            r_sum;

    logic                    w_clear;
    logic                    w_accept;
    logic                    w_last_beat;
    logic signed [8:0]       w_prod [LANES];
    logic [7:0]              w_lane [LANES];

    // start is only honoured outside ACCUM/FLUSH; a beat is only taken in ACCUM,
    // so start+inValid together in IDLE/DONE never accepts a beat.
    assign w_clear     = start && ((r_state == StIdle) || (r_state == StDone));
    assign w_accept    = (r_state == StAccum) && inValid;
    assign w_last_beat = (r_count == CNT_W'(N_INPUTS - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (start) w_state_nxt = StAccum;
            StAccum: if (w_accept && w_last_beat) w_state_nxt = StFlush;
            StFlush: w_state_nxt = StDone;
            StDone:  if (start) w_state_nxt = StAccum;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Signed weight times zero-extended activation; range -120..105 fits in 9 bits.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            w_prod[j] = 9'($signed(weightsIn[4*j +: 4])) * 9'($signed({1'b0, inData}));
        end
    end

`ifdef LAYER1_ACC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(128);

    logic signed [ACC_W-1:0] w_t [LANES];

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            w_t[j] = r_acc[j] >>> SHIFT;
            if (w_t[j] > SAT_MAX) begin
                w_lane[j] = 8'h7f;
            end else if (w_t[j] < SAT_MIN) begin
                w_lane[j] = 8'h80;
            end else begin
                w_lane[j] = w_t[j][7:0];
            end
        end
    end
`else
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            w_lane[j] = 8'(r_acc[j] >>> SHIFT);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_count    <= '0;
            r_in_ready <= 1'b0;
            r_trigger  <= 1'b0;
            r_sum      <= '0;
            for (int j = 0; j < LANES; j++) begin
                r_acc[j] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            // Registered from next state so inReady has no path from inputs.
            r_in_ready <= (w_state_nxt == StAccum);

            if (w_clear) begin
                r_count   <= '0;
                r_trigger <= 1'b0;
                for (int j = 0; j < LANES; j++) begin
                    r_acc[j] <= '0;
                end
            end else if (w_accept) begin
                r_count <= r_count + CNT_W'(1);
                for (int j = 0; j < LANES; j++) begin
                    r_acc[j] <= r_acc[j] + ACC_W'(w_prod[j]);
                end
            end

            if (r_state == StFlush) begin
                r_trigger <= 1'b1;
                for (int j = 0; j < LANES; j++) begin
                    r_sum[8*j +: 8] <= w_lane[j];
                end
            end
        end
    end

    assign inReady = r_in_ready;
    assign trigger = r_trigger;
    assign sumOut  = r_sum;

endmodule

// File: tb/tb_layer1_accumulator.sv
module tb_layer1_accumulator;

    localparam int N     = 64;
    localparam int SHIFT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         inValid = 1'b0;
    logic [3:0]   inData = 4'd0;
    logic [127:0] weightsIn = '0;
    logic         inReady;
    logic [255:0] sumOut;
    logic         trigger;

    always #5 clk = ~clk;

    layer1_accumulator #(
        .N_INPUTS(N),
        .ACC_W   (16),
        .SHIFT   (SHIFT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .inValid  (inValid),
        .inReady  (inReady),
        .inData   (inData),
        .weightsIn(weightsIn),
        .sumOut   (sumOut),
        .trigger  (trigger)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: frame-level behaviour with plain integer sums.
    bit           chk_en = 0;
    bit           m_acc_on = 0;
    bit           m_flush = 0;
    bit           m_trig = 0;
    int           m_cnt = 0;
    logic [255:0] m_sum = '0;
    int           acc [32];
    int           m_start_edge = 0;
    int           m_last_edge = 0;
    int           dut_trig_edge = -1;
    logic         prev_trig = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] narrow(input int a);
        int t;
        t = a >>> SHIFT;
`ifdef LAYER1_ACC_SATURATE_EN
        if (t > 127) return 8'h7f;
        if (t < -128) return 8'h80;
`endif
        return 8'(t);
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            chk_en   = 1;
            m_acc_on = 0;
            m_flush  = 0;
            m_trig   = 0;
            m_cnt    = 0;
            m_sum    = '0;
            for (int j = 0; j < 32; j++) acc[j] = 0;
        end else if (m_flush) begin
            for (int j = 0; j < 32; j++) m_sum[8*j +: 8] = narrow(acc[j]);
            m_trig  = 1;
            m_flush = 0;
        end else if (m_acc_on) begin
            if (inValid) begin
                for (int j = 0; j < 32; j++) begin
                    acc[j] += int'($signed(weightsIn[4*j +: 4])) * int'(inData);
                end
                m_cnt++;
                if (m_cnt == N) begin
                    m_acc_on    = 0;
                    m_flush     = 1;
                    m_last_edge = cyc;
                end
            end
        end else if (start) begin
            for (int j = 0; j < 32; j++) acc[j] = 0;
            m_cnt        = 0;
            m_acc_on     = 1;
            m_trig       = 0;
            m_start_edge = cyc;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("inReady", 256'(inReady), 256'(m_acc_on));
                check("trigger", 256'(trigger), 256'(m_trig));
                check("sumOut", sumOut, m_sum);
                if (trigger === 1'b1 && prev_trig !== 1'b1) dut_trig_edge = cyc;
                prev_trig = trigger;
            end
        end
    end

    // mode 0: x=1,w=+1  1: x=15,w=-8  2: x=3,w=clamp(j-16)  3: random
    task automatic set_inputs(input int mode);
        int w;
        for (int j = 0; j < 32; j++) begin
            case (mode)
                0: w = 1;
                1: w = -8;
                2: w = (j - 16 < -8) ? -8 : ((j - 16 > 7) ? 7 : j - 16);
                default: w = int'($urandom_range(15));
            endcase
            weightsIn[4*j +: 4] = 4'(w);
        end
        case (mode)
            0: inData = 4'd1;
            1: inData = 4'd15;
            2: inData = 4'd3;
            default: inData = 4'($urandom_range(15));
        endcase
    endtask

    task automatic run_frame(input int mode, input int stall, input int mid_start, input int abort_beat);
        int budget;
        @(posedge clk);
        #1;
        dut_trig_edge = -1;
        start   = 1'b1;
        inValid = 1'($urandom_range(1));
        set_inputs(mode);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("trig_clear_on_start", 256'(trigger), 256'(0));
        budget = 2000;
        while (m_acc_on && budget > 0) begin
            if (abort_beat >= 0 && m_cnt == abort_beat) begin
                rst_n   = 1'b0;
                inValid = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            inValid = ($urandom_range(99) >= stall);
            start   = (m_cnt == mid_start);
            set_inputs(mode);
            @(posedge clk);
            #1;
            budget--;
        end
        start   = 1'b0;
        inValid = 1'b0;
        if (budget == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_budget: got beats=%0d expected %0d", m_cnt, N);
        end
    endtask

    task automatic wait_trigger();
        int budget;
        budget = 10;
        while (trigger !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        #1;
        check("trigger_rises", 256'(trigger), 256'(1));
        check("trig_after_last_beat", 256'(dut_trig_edge), 256'(m_last_edge + 1));
    endtask

    initial begin
        logic [255:0] exp_b;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_sumOut", sumOut, '0);
        check("rst_trigger", 256'(trigger), 256'(0));
        check("rst_inReady", 256'(inReady), 256'(0));
        repeat (10) @(posedge clk);

        // All ones, no stalls; latency counts the start cycle as cycle 1.
        run_frame(0, 0, -1, -1);
        wait_trigger();
        check("latency_nostall", 256'(dut_trig_edge - m_start_edge + 1), 256'(N + 2));
        check("ones_lanes", sumOut, {32{8'h04}});

        // Most negative products: acc=-7680, t=-480.
        run_frame(1, 0, -1, -1);
        wait_trigger();
`ifdef LAYER1_ACC_SATURATE_EN
        exp_b = {32{8'h80}};
`else
        exp_b = {32{8'h20}};
`endif
        check("neg_lanes", sumOut, exp_b);
        check("latency_nostall2", 256'(dut_trig_edge - m_start_edge + 1), 256'(N + 2));

        // Ramp weights with ~50% stalls: t = 12*w, lane0 w=-8, lane31 w=7.
        run_frame(2, 50, -1, -1);
        wait_trigger();
        check("ramp_lane0", 256'(sumOut[7:0]), 256'(8'hA0));
        check("ramp_lane31", 256'(sumOut[255:248]), 256'(8'h54));

        // start during ACCUM at beat 10 is ignored.
        run_frame(3, 30, 10, -1);
        wait_trigger();

        // Reset at beat 30 aborts; next frame must show no residue.
        run_frame(3, 20, -1, 30);
        repeat (5) @(posedge clk);
        #1;
        check("abort_trigger", 256'(trigger), 256'(0));
        check("abort_inReady", 256'(inReady), 256'(0));
        check("abort_sumOut", sumOut, '0);
        run_frame(2, 0, -1, -1);
        wait_trigger();
        check("post_abort_lane0", 256'(sumOut[7:0]), 256'(8'hA0));
        check("post_abort_lane31", 256'(sumOut[255:248]), 256'(8'h54));

        for (int i = 0; i < 3; i++) begin
            run_frame(3, 50, -1, -1);
            wait_trigger();
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
